// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - packs decoded commands into 32-bit instructions and streams them into I-mem (optional feature macro: ENC_RAW_EN)
module instr_encoder_loader #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] count,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [4:0]    cmd_rd,
    input  logic [4:0]    cmd_rs,
    input  logic [4:0]    cmd_rt,
    input  logic [3:0]    cmd_alu,
    input  logic [1:0]    cmd_cond,
    input  logic [11:0]   cmd_imm,
    input  logic [31:0]   cmd_raw,
    output logic          im_we,
    output logic [AW-1:0] im_addr,
    output logic [31:0]   im_wdata,
    output logic          busy,
    output logic          done,
    output logic          err
);

    // Canonical no-op (ADDI x0, x0, 0) substituted for anything we cannot encode.
    localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;

    localparam logic [2:0]  OP_LW      = 3'd0;
    localparam logic [2:0]  OP_SW      = 3'd1;
    localparam logic [2:0]  OP_ADDI    = 3'd2;
    localparam logic [2:0]  OP_R       = 3'd3;
    localparam logic [2:0]  OP_BR      = 3'd4;
    localparam logic [2:0]  OP_JAL     = 3'd5;
    localparam logic [2:0]  OP_RSVD    = 3'd6;
    localparam logic [2:0]  OP_RAW     = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [AW-1:0] ptr;
    logic [AW-1:0] remaining;
    logic          remaining_nz;
    logic          start_ok;
    logic          accept;

    logic [31:0]   enc_word;
    logic          enc_illegal;
    logic [2:0]    br_f3;

    assign remaining_nz = (remaining != '0);
    assign start_ok     = start && (state == ST_IDLE);
    assign accept       = cmd_valid && cmd_ready;

`ifndef ENC_RAW_EN
    // The raw word only matters when raw pass-through is built in.
    logic unused_raw;
    assign unused_raw = ^cmd_raw;
`endif

    // State register; reset aborts any load in progress with no done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the handshake/status outputs that follow the state directly.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (count != '0) ? ST_RUN : ST_FIN;
                end
            end
            ST_RUN: begin
                busy      = 1'b1;
                cmd_ready = remaining_nz;
                // One idle RUN cycle after the last accept lets its write land before done.
                if (!remaining_nz) begin
                    state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Instruction packer: maps the decoded command onto the RV-style field layout.
    always_comb begin
        enc_word    = NOP_WORD;
        enc_illegal = 1'b0;
        br_f3       = 3'b000;
        case (cmd_op)
            OP_LW: begin
                enc_word = {cmd_imm, cmd_rs, 3'b011, cmd_rd, OPC_LOAD};
            end
            OP_SW: begin
                enc_word = {cmd_imm[11:5], cmd_rt, cmd_rs, 3'b011, cmd_imm[4:0], OPC_STORE};
            end
            OP_ADDI: begin
                enc_word = {cmd_imm, cmd_rs, 3'b000, cmd_rd, OPC_OPIMM};
            end
            OP_R: begin
                enc_word = {1'b0, cmd_alu[3], 5'b00000, cmd_rt, cmd_rs, cmd_alu[2:0], cmd_rd, OPC_OP};
            end
            OP_BR: begin
                case (cmd_cond)
                    2'b00:   br_f3 = 3'b000;
                    2'b01:   br_f3 = 3'b001;
                    2'b10:   br_f3 = 3'b100;
                    default: enc_illegal = 1'b1;
                endcase
                if (!enc_illegal) begin
                    enc_word = {cmd_imm[11], cmd_imm[9:4], cmd_rt, cmd_rs, br_f3,
                                cmd_imm[3:0], cmd_imm[10], OPC_BRANCH};
                end
            end
            OP_JAL: begin
                enc_word = {cmd_imm[11], cmd_imm[9:0], cmd_imm[10], {8{cmd_imm[11]}},
                            cmd_rd, OPC_JAL};
            end
            OP_RSVD: begin
                enc_illegal = 1'b1;
            end
            OP_RAW: begin
`ifdef ENC_RAW_EN
                enc_word = cmd_raw;
`else
                enc_illegal = 1'b1;
`endif
            end
            default: begin
                enc_illegal = 1'b1;
            end
        endcase
    end

    // Load bookkeeping and the registered I-mem write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            remaining <= '0;
            im_we     <= 1'b0;
            im_addr   <= '0;
            im_wdata  <= 32'h0000_0000;
            err       <= 1'b0;
        end else begin
            im_we <= accept;
            if (start_ok) begin
                ptr       <= base_addr;
                remaining <= count;
                err       <= 1'b0;
            end
            // Illegal commands still occupy a slot and an address, written as NOP.
            if (accept) begin
                im_addr   <= ptr;
                im_wdata  <= enc_word;
                ptr       <= ptr + 1'b1;
                remaining <= remaining - 1'b1;
                if (enc_illegal) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - self-checking bench for instr_encoder_loader
module tb_instr_encoder_loader;

    localparam int AW = 10;

    typedef struct packed {
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [3:0]  alu;
        logic [1:0]  cond;
        logic [11:0] imm;
        logic [31:0] raw;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] count;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [4:0]    cmd_rd;
    logic [4:0]    cmd_rs;
    logic [4:0]    cmd_rt;
    logic [3:0]    cmd_alu;
    logic [1:0]    cmd_cond;
    logic [11:0]   cmd_imm;
    logic [31:0]   cmd_raw;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic          busy;
    logic          done;
    logic          err;

    instr_encoder_loader #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_rd(cmd_rd),
        .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_alu(cmd_alu), .cmd_cond(cmd_cond),
        .cmd_imm(cmd_imm), .cmd_raw(cmd_raw), .im_we(im_we), .im_addr(im_addr),
        .im_wdata(im_wdata), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [AW-1:0] wr_addr_q[$];
    logic [31:0]   wr_data_q[$];
    int            wr_cyc_q[$];
    int            done_cyc_q[$];
    logic          done_busy_q[$];
    cmd_t          cmdq[$];
    logic [31:0]   expq[$];
    int            acc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the write port and done pulses away from the active edge.
    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            wr_addr_q.push_back(im_addr);
            wr_data_q.push_back(im_wdata);
            wr_cyc_q.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cyc_q.push_back(cyc);
            done_busy_q.push_back(busy);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_illegal(input cmd_t c);
`ifdef ENC_RAW_EN
        return (c.op == 3'd6) || (c.op == 3'd4 && c.cond == 2'd3);
`else
        return (c.op == 3'd6) || (c.op == 3'd7) || (c.op == 3'd4 && c.cond == 2'd3);
`endif
    endfunction

    // Reference encoder built from field positions with shifts and masks.
    function automatic logic [31:0] model_word(input cmd_t c);
        int unsigned imm, s11, s10, f3, rd, rs, rt, alu;
        imm = 32'(c.imm);
        s11 = (imm >> 11) & 1;
        s10 = (imm >> 10) & 1;
        rd  = 32'(c.rd);
        rs  = 32'(c.rs);
        rt  = 32'(c.rt);
        alu = 32'(c.alu);
        if (model_illegal(c)) return 32'h13;
        case (c.op)
            3'd0: return (imm << 20) + (rs << 15) + (3 << 12) + (rd << 7) + 32'h03;
            3'd1: return ((imm >> 5) << 25) + (rt << 20) + (rs << 15) + (3 << 12)
                         + ((imm % 32) << 7) + 32'h23;
            3'd2: return (imm << 20) + (rs << 15) + (rd << 7) + 32'h13;
            3'd3: return ((alu / 8) << 30) + (rt << 20) + (rs << 15) + ((alu % 8) << 12)
                         + (rd << 7) + 32'h33;
            3'd4: begin
                f3 = (c.cond == 2'd0) ? 0 : (c.cond == 2'd1) ? 1 : 4;
                return (s11 << 31) + (((imm >> 4) & 63) << 25) + (rt << 20) + (rs << 15)
                       + (f3 << 12) + ((imm & 15) << 8) + (s10 << 7) + 32'h63;
            end
            3'd5: return (s11 << 31) + ((imm & 1023) << 21) + (s10 << 20)
                         + ((s11 * 255) << 12) + (rd << 7) + 32'h6F;
            default: return c.raw;
        endcase
    endfunction

    function automatic cmd_t mk(input int op, input int rd, input int rs, input int rt,
                                input int alu, input int cond, input int imm);
        cmd_t c;
        c.op   = 3'(op);
        c.rd   = 5'(rd);
        c.rs   = 5'(rs);
        c.rt   = 5'(rt);
        c.alu  = 4'(alu);
        c.cond = 2'(cond);
        c.imm  = 12'(imm);
        c.raw  = $urandom;
        return c;
    endfunction

    function automatic cmd_t rnd_cmd(input int max_op);
        return mk($urandom_range(0, max_op), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 15), $urandom_range(0, 3),
                  $urandom_range(0, 4095));
    endfunction

    task automatic drive_cmd(input cmd_t c);
        cmd_op   = c.op;
        cmd_rd   = c.rd;
        cmd_rs   = c.rs;
        cmd_rt   = c.rt;
        cmd_alu  = c.alu;
        cmd_cond = c.cond;
        cmd_imm  = c.imm;
        cmd_raw  = c.raw;
    endtask

    task automatic clear_obs();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        done_cyc_q.delete();
        done_busy_q.delete();
        acc_q.delete();
    endtask

    // Offer one command (optionally after idle gaps carrying junk) until accepted.
    task automatic send_cmd(input cmd_t c, input bit gaps);
        int guard;
        bit ok;
        if (gaps) begin
            for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
                cmd_valid = 1'b0;
                drive_cmd(rnd_cmd(7));
                @(negedge clk);
            end
        end
        drive_cmd(c);
        cmd_valid = 1'b1;
        ok = 1'b0;
        guard = 0;
        while (!ok && guard < 40) begin
            if (cmd_ready === 1'b1) begin
                ok = 1'b1;
                acc_q.push_back(cyc);
            end
            @(negedge clk);
            guard++;
        end
        cmd_valid = 1'b0;
        chk("accept", 32'(ok), 32'd1);
    endtask

    // Full load of cmdq at base b, checked against expq and exp_err.
    task automatic run_load(input logic [AW-1:0] b, input bit gaps, input bit exp_err,
                            input string tag);
        int n, start_cyc, guard, exp_done;
        n = cmdq.size();
        clear_obs();
        base_addr = b;
        count     = AW'(n);
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start     = 1'b0;
        base_addr = AW'($urandom);
        count     = AW'($urandom);
        if (n > 0) chk({tag, "_busy"}, 32'(busy), 32'd1);
        foreach (cmdq[i]) send_cmd(cmdq[i], gaps);
        guard = 0;
        while (done_cyc_q.size() == 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_nwrites"}, 32'(wr_addr_q.size()), 32'(n));
        chk({tag, "_ndone"}, 32'(done_cyc_q.size()), 32'd1);
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 32'(wr_addr_q[i]), 32'((int'(b) + i) % (1 << AW)));
            chk($sformatf("%s_data%0d", tag, i), wr_data_q[i], expq[i]);
            if (i < acc_q.size())
                chk($sformatf("%s_lat%0d", tag, i), 32'(wr_cyc_q[i]), 32'(acc_q[i] + 1));
        end
        exp_done = (n == 0) ? start_cyc + 1 : ((acc_q.size() > 0) ? acc_q[$] + 2 : -1);
        if (done_cyc_q.size() > 0) begin
            chk({tag, "_donecyc"}, 32'(done_cyc_q[0]), 32'(exp_done));
            chk({tag, "_busy_at_done"}, 32'(done_busy_q[0]), 32'd0);
        end
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        cmdq.delete();
        expq.delete();
    endtask

    task automatic push_model(input cmd_t c, inout bit e);
        cmdq.push_back(c);
        expq.push_back(model_word(c));
        if (model_illegal(c)) e = 1'b1;
    endtask

    initial begin
        bit   e;
        int   n;
        cmd_t c;
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        count = '0;
        cmd_valid = 1'b0;
        drive_cmd(mk(0, 0, 0, 0, 0, 0, 0));
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_we", 32'(im_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_addr", 32'(im_addr), 32'd0);
        chk("rst_wdata", im_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1
        cmdq.push_back(mk(2, 1, 0, 0, 0, 0, 5));
        expq.push_back(32'h00500093);
        run_load(10'h010, 1'b0, 1'b0, "t1");

        // T2
        cmdq.push_back(mk(0, 2, 1, 0, 0, 0, 8));
        expq.push_back(32'h0080B103);
        cmdq.push_back(mk(1, 0, 1, 2, 0, 0, 4));
        expq.push_back(32'h0020B223);
        cmdq.push_back(mk(3, 3, 1, 2, 8, 0, 0));
        expq.push_back(32'h402081B3);
        run_load(10'h020, 1'b0, 1'b0, "t2");

        // T3
        cmdq.push_back(mk(4, 0, 1, 2, 0, 1, 12'h004));
        expq.push_back(32'h00209463);
        cmdq.push_back(mk(5, 0, 0, 0, 0, 0, 12'hFFE));
        expq.push_back(32'hFFDFF06F);
        run_load(10'h100, 1'b0, 1'b0, "t3");

        // T4: pointer wrap with random valid gaps
        e = 1'b0;
        for (int i = 0; i < 3; i++) begin
            c = rnd_cmd(5);
            if (c.cond == 2'd3) c.cond = 2'd2;
            push_model(c, e);
        end
        run_load(10'h3FF, 1'b1, e, "t4");

        // T5: illegal commands, err clear on new start, zero-length load
        cmdq.push_back(mk(6, 7, 7, 7, 0, 0, 123));
        expq.push_back(32'h00000013);
        run_load(10'h050, 1'b0, 1'b1, "t5_rsvd");
        cmdq.push_back(mk(2, 1, 0, 0, 0, 0, 5));
        expq.push_back(32'h00500093);
        run_load(10'h060, 1'b0, 1'b0, "t5_clear");
        e = 1'b0;
        push_model(mk(4, 1, 2, 3, 0, 3, 12'h0F0), e);
        push_model(mk(7, 1, 2, 3, 0, 0, 0), e);
        run_load(10'h070, 1'b0, e, "t5_brraw");
        run_load(10'h080, 1'b0, 1'b0, "t5_zero");

        // Randomised loads against the reference encoder
        for (int k = 0; k < 5; k++) begin
            e = 1'b0;
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) push_model(rnd_cmd(7), e);
            run_load(AW'($urandom), 1'b1, e, $sformatf("rnd%0d", k));
        end

        // T6: reset after 2 of 4 writes
        clear_obs();
        base_addr = 10'h200;
        count = 10'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_cmd(mk(2, 1, 0, 0, 0, 0, 1), 1'b0);
        send_cmd(mk(2, 2, 0, 0, 0, 0, 2), 1'b0);
        @(negedge clk);
        drive_cmd(mk(2, 3, 0, 0, 0, 0, 3));
        cmd_valid = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_nwrites", 32'(wr_addr_q.size()), 32'd2);
        chk("t6_ndone", 32'(done_cyc_q.size()), 32'd0);
        chk("t6_we", 32'(im_we), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_ready", 32'(cmd_ready), 32'd0);
        cmdq.push_back(mk(0, 2, 1, 0, 0, 0, 8));
        expq.push_back(32'h0080B103);
        run_load(10'h300, 1'b0, 1'b0, "t6_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
